// File: rtl/dataio_mem_responder.sv
// -----------------------------------------------------------------------------
// dataio_mem_responder
//
// Memory-side responder for the core's data-IO port. Accepts one load/store
// request at a time from the execute stage (REQ/BUSY handshake), turns the
// access order and byte address into a word-aligned address plus byte-enables,
// runs a single transaction on the data memory bus and returns a one-cycle
// completion pulse carrying the raw (unshifted) 32-bit read word.
//
// Optional feature macro: DATAIO_MISALIGN_FAULT_EN
//   defined   : misaligned halfword/word accesses skip memory and complete
//               immediately with oCORE_FAULT=1 and oCORE_DATA=0.
//   undefined : oCORE_FAULT is always 0; a misaligned access is issued with
//               ADDR[1:0] dropped (halfword lane chosen by ADDR[1], word=1111).
//
// Ports
//   iCLOCK, inRESET (async, active-low), iRESET_SYNC (synchronous flush)
//   Core side : iCORE_REQ, oCORE_BUSY, iCORE_ORDER, iCORE_MASK, iCORE_RW,
//               iCORE_TID, iCORE_MMUMOD, iCORE_PDT, iCORE_ADDR, iCORE_DATA,
//               oCORE_VALID, oCORE_DATA, oCORE_FAULT
//   Memory    : oMEM_REQ, iMEM_BUSY, oMEM_RW, oMEM_ADDR, oMEM_BE, oMEM_DATA,
//               oMEM_TID, oMEM_MMUMOD, oMEM_PDT, iMEM_VALID, iMEM_DATA
// -----------------------------------------------------------------------------
module dataio_mem_responder (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  // core request side
  input  logic        iCORE_REQ,
  output logic        oCORE_BUSY,
  input  logic [1:0]  iCORE_ORDER,
  input  logic [3:0]  iCORE_MASK,
  input  logic        iCORE_RW,
  input  logic [13:0] iCORE_TID,
  input  logic [1:0]  iCORE_MMUMOD,
  input  logic [31:0] iCORE_PDT,
  input  logic [31:0] iCORE_ADDR,
  input  logic [31:0] iCORE_DATA,
  // core response side
  output logic        oCORE_VALID,
  output logic [31:0] oCORE_DATA,
  output logic        oCORE_FAULT,
  // memory bus
  output logic        oMEM_REQ,
  input  logic        iMEM_BUSY,
  output logic        oMEM_RW,
  output logic [31:0] oMEM_ADDR,
  output logic [3:0]  oMEM_BE,
  output logic [31:0] oMEM_DATA,
  output logic [13:0] oMEM_TID,
  output logic [1:0]  oMEM_MMUMOD,
  output logic [31:0] oMEM_PDT,
  input  logic        iMEM_VALID,
  input  logic [31:0] iMEM_DATA
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEMREQ  = 3'd1,
    ST_MEMWAIT = 3'd2,
    ST_RESP    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  // Byte-enables for the aligned word; misaligned low bits are ignored here.
  function automatic logic [3:0] calc_be(input logic [1:0] order, input logic [1:0] lo);
    logic [3:0] be;
    case (order)
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data onto every lane the access may hit.
  function automatic logic [31:0] calc_lanes(input logic [1:0] order, input logic [31:0] data);
    logic [31:0] lanes;
    case (order)
      2'b00:   lanes = {4{data[7:0]}};
      2'b01:   lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

`ifdef DATAIO_MISALIGN_FAULT_EN
  // Halfword needs ADDR[0]=0, word needs ADDR[1:0]=0.
  function automatic logic calc_misaligned(input logic [1:0] order, input logic [1:0] lo);
    logic mis;
    case (order)
      2'b01:   mis = lo[0];
      2'b10:   mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction
`endif

  state_t      state_r;
  logic        busy_r;
  logic        valid_r;
  logic        fault_r;
  logic [31:0] core_data_r;
  logic        mem_req_r;
  logic        mem_rw_r;
  logic [31:0] mem_addr_r;
  logic [3:0]  mem_be_r;
  logic [31:0] mem_data_r;
  logic [13:0] mem_tid_r;
  logic [1:0]  mem_mmumod_r;
  logic [31:0] mem_pdt_r;

  logic        fault_s;
  logic        skip_s;
  logic        unused_mask_s;

  // The load mask travels with the request but has no consumer on this bus.
  assign unused_mask_s = ^iCORE_MASK;

  // Decide whether an incoming request bypasses the memory bus.
  always_comb begin
    fault_s = 1'b0;
    skip_s  = 1'b0;
`ifdef DATAIO_MISALIGN_FAULT_EN
    fault_s = calc_misaligned(iCORE_ORDER, iCORE_ADDR[1:0]);
`else
    fault_s = 1'b0;
`endif
    if (iCORE_ORDER == 2'b11) begin
      skip_s = 1'b1;
    end else begin
      skip_s = fault_s;
    end
  end

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      valid_r      <= 1'b0;
      fault_r      <= 1'b0;
      core_data_r  <= 32'h0000_0000;
      mem_req_r    <= 1'b0;
      mem_rw_r     <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
      mem_be_r     <= 4'b0000;
      mem_data_r   <= 32'h0000_0000;
      mem_tid_r    <= 14'h0000;
      mem_mmumod_r <= 2'b00;
      mem_pdt_r    <= 32'h0000_0000;
    end else begin
      // Completion is a single-cycle pulse unless RESP is being entered.
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (iRESET_SYNC) begin
            busy_r    <= 1'b0;
            mem_req_r <= 1'b0;
          end else if (iCORE_REQ) begin
            busy_r       <= 1'b1;
            mem_rw_r     <= iCORE_RW;
            mem_addr_r   <= {iCORE_ADDR[31:2], 2'b00};
            mem_be_r     <= calc_be(iCORE_ORDER, iCORE_ADDR[1:0]);
            mem_data_r   <= calc_lanes(iCORE_ORDER, iCORE_DATA);
            mem_tid_r    <= iCORE_TID;
            mem_mmumod_r <= iCORE_MMUMOD;
            mem_pdt_r    <= iCORE_PDT;
            if (skip_s) begin
              // No-op order or faulting access: answer without touching memory.
              state_r     <= ST_RESP;
              valid_r     <= 1'b1;
              fault_r     <= fault_s;
              core_data_r <= 32'h0000_0000;
              mem_req_r   <= 1'b0;
            end else begin
              state_r   <= ST_MEMREQ;
              mem_req_r <= 1'b1;
            end
          end else begin
            busy_r    <= 1'b0;
            mem_req_r <= 1'b0;
          end
        end

        ST_MEMREQ: begin
          if (iRESET_SYNC) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            mem_req_r <= 1'b0;
          end else if (!iMEM_BUSY) begin
            state_r   <= ST_MEMWAIT;
            mem_req_r <= 1'b0;
          end else begin
            // Memory stalled: request and latched payload stay put.
            mem_req_r <= 1'b1;
          end
        end

        ST_MEMWAIT: begin
          if (iMEM_VALID) begin
            if (iRESET_SYNC) begin
              // Flush coincides with the reply: bus is clean, drop the result.
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r     <= ST_RESP;
              valid_r     <= 1'b1;
              fault_r     <= 1'b0;
              core_data_r <= mem_rw_r ? 32'h0000_0000 : iMEM_DATA;
            end
          end else if (iRESET_SYNC) begin
            // Reply still outstanding on the bus; swallow it before going idle.
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_MEMWAIT;
          end
        end

        ST_RESP: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end

        ST_DRAIN: begin
          if (iMEM_VALID) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_DRAIN;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign oCORE_BUSY  = busy_r;
  // A flush arriving in the RESP cycle cancels the completion pulse.
  assign oCORE_VALID = valid_r & ~iRESET_SYNC;
  assign oCORE_DATA  = core_data_r;
`ifdef DATAIO_MISALIGN_FAULT_EN
  assign oCORE_FAULT = fault_r;
`else
  assign oCORE_FAULT = 1'b0 & fault_r;
`endif
  assign oMEM_REQ    = mem_req_r;
  assign oMEM_RW     = mem_rw_r;
  assign oMEM_ADDR   = mem_addr_r;
  assign oMEM_BE     = mem_be_r;
  assign oMEM_DATA   = mem_data_r;
  assign oMEM_TID    = mem_tid_r;
  assign oMEM_MMUMOD = mem_mmumod_r;
  assign oMEM_PDT    = mem_pdt_r;

endmodule

// File: tb/tb_dataio_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_dataio_mem_responder
//
// Directed self-checking bench. Each transaction derives its expected
// byte-enables, store lanes, response data and cycle timing from the access
// rules, then a per-cycle loop compares the DUT against those expectations.
// Literal expectations from hand-worked examples pin the model.
// -----------------------------------------------------------------------------
module tb_dataio_mem_responder;

`ifdef DATAIO_MISALIGN_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        srst;
  logic        core_req;
  logic        core_busy;
  logic [1:0]  core_order;
  logic [3:0]  core_mask;
  logic        core_rw;
  logic [13:0] core_tid;
  logic [1:0]  core_mmumod;
  logic [31:0] core_pdt;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_valid;
  logic [31:0] core_rdata;
  logic        core_fault;
  logic        mem_req;
  logic        mem_busy;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [13:0] mem_tid;
  logic [1:0]  mem_mmumod;
  logic [31:0] mem_pdt;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  int n_total = 0;
  int n_pass  = 0;

  // observations from the most recent run_req
  logic [31:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  logic [31:0] last_rdata;
  logic        last_fault;
  int          last_vc;
  int          last_nreq;

  dataio_mem_responder dut (
    .iCLOCK      (clk),
    .inRESET     (rst_n),
    .iRESET_SYNC (srst),
    .iCORE_REQ   (core_req),
    .oCORE_BUSY  (core_busy),
    .iCORE_ORDER (core_order),
    .iCORE_MASK  (core_mask),
    .iCORE_RW    (core_rw),
    .iCORE_TID   (core_tid),
    .iCORE_MMUMOD(core_mmumod),
    .iCORE_PDT   (core_pdt),
    .iCORE_ADDR  (core_addr),
    .iCORE_DATA  (core_wdata),
    .oCORE_VALID (core_valid),
    .oCORE_DATA  (core_rdata),
    .oCORE_FAULT (core_fault),
    .oMEM_REQ    (mem_req),
    .iMEM_BUSY   (mem_busy),
    .oMEM_RW     (mem_rw),
    .oMEM_ADDR   (mem_addr),
    .oMEM_BE     (mem_be),
    .oMEM_DATA   (mem_wdata),
    .oMEM_TID    (mem_tid),
    .oMEM_MMUMOD (mem_mmumod),
    .oMEM_PDT    (mem_pdt),
    .iMEM_VALID  (mem_valid),
    .iMEM_DATA   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // ---- access rules ----
  function automatic bit m_misaligned(input logic [1:0] o, input logic [31:0] a);
    return (o == 2'b01 && a[0] == 1'b1) || (o == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] o, input logic [31:0] a);
    if (o == 2'b00) return 4'(1 << a[1:0]);
    if (o == 2'b01) return (a[1] == 1'b1) ? 4'b1100 : 4'b0011;
    if (o == 2'b10) return 4'b1111;
    return 4'b0000;
  endfunction

  function automatic logic [31:0] m_lanes(input logic [1:0] o, input logic [31:0] d);
    if (o == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (o == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  // One request, with busy_n stall cycles and wait_n extra cycles before the reply.
  task automatic run_req(input logic [1:0] o, input logic rw, input logic [31:0] a,
                         input logic [31:0] d, input int busy_n, input int wait_n,
                         input logic [31:0] mw);
    bit skip, efault;
    int exp_vc, exp_nreq, mv_cycle, nval, nreq, vc;
    logic [31:0] ercv;
    logic [13:0] t;
    logic [1:0]  mm;
    logic [31:0] p;
    t = 14'($urandom); mm = 2'($urandom); p = $urandom;
    efault   = FAULT_EN && m_misaligned(o, a);
    skip     = (o == 2'b11) || efault;
    exp_vc   = skip ? 1 : busy_n + 3 + wait_n;
    exp_nreq = skip ? 0 : busy_n + 1;
    ercv     = (skip || rw) ? 32'h0 : mw;
    mv_cycle = -1; nval = 0; nreq = 0; vc = -1;

    @(posedge clk); #1;
    core_req = 1'b1; core_order = o; core_rw = rw; core_addr = a; core_wdata = d;
    core_tid = t; core_mmumod = mm; core_pdt = p; core_mask = 4'($urandom);
    for (int c = 1; c <= exp_vc + 3; c++) begin
      @(posedge clk); #1;
      core_req   = 1'b0;
      core_wdata = $urandom;
      mem_busy   = (c <= busy_n);
      mem_valid  = (c == mv_cycle);
      mem_rdata  = (c == mv_cycle) ? mw : $urandom;
      chk("busy", 32'(core_busy), 32'(c <= exp_vc));
      if (mem_req) begin
        nreq++;
        obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata;
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_be", 32'(mem_be), 32'(m_be(o, a)));
        chk("mem_rw", 32'(mem_rw), 32'(rw));
        chk("mem_tid", 32'(mem_tid), 32'(t));
        chk("mem_mmumod", 32'(mem_mmumod), 32'(mm));
        chk("mem_pdt", mem_pdt, p);
        if (rw) chk("mem_wdata", mem_wdata, m_lanes(o, d));
        if (!mem_busy) mv_cycle = c + 1 + wait_n;
      end
      if (core_valid) begin
        nval++; vc = c;
        last_rdata = core_rdata; last_fault = core_fault;
        chk("rsp_data", core_rdata, ercv);
        chk("rsp_fault", 32'(core_fault), 32'(efault));
      end
    end
    mem_valid = 1'b0; mem_busy = 1'b0;
    chk("valid_count", 32'(nval), 32'd1);
    chk("valid_cycle", 32'(vc), 32'(exp_vc));
    chk("mem_req_cycles", 32'(nreq), 32'(exp_nreq));
    last_vc = vc; last_nreq = nreq;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; srst = 1'b0; core_req = 1'b0; core_order = 2'b00; core_mask = 4'h0;
    core_rw = 1'b0; core_tid = 14'h0; core_mmumod = 2'b00; core_pdt = 32'h0;
    core_addr = 32'h0; core_wdata = 32'h0; mem_busy = 1'b0; mem_valid = 1'b0;
    mem_rdata = 32'h0;
    obs_addr = 32'h0; obs_be = 4'h0; obs_wdata = 32'h0; last_rdata = 32'h0;
    last_fault = 1'b0; last_vc = 0; last_nreq = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(core_busy), 32'd0);
    chk("rst_valid", 32'(core_valid), 32'd0);
    chk("rst_fault", 32'(core_fault), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_core_data", core_rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // word load, zero wait
    run_req(2'b10, 1'b0, 32'h0000_1004, 32'h0, 0, 0, 32'hDEAD_BEEF);
    chk("t1_addr", obs_addr, 32'h0000_1004);
    chk("t1_be", 32'(obs_be), 32'h0000_000F);
    chk("t1_cycle", 32'(last_vc), 32'd3);
    chk("t1_data", last_rdata, 32'hDEAD_BEEF);

    // byte store to lane 3
    run_req(2'b00, 1'b1, 32'h0000_2003, 32'h0000_00A5, 0, 1, 32'h1234_5678);
    chk("t2_be", 32'(obs_be), 32'h0000_0008);
    chk("t2_wdata", obs_wdata, 32'hA5A5_A5A5);
    chk("t2_data", last_rdata, 32'h0);

    // halfword load with memory stall
    run_req(2'b01, 1'b0, 32'h0000_0012, 32'h0, 3, 0, 32'hCAFE_F00D);
    chk("t3_be", 32'(obs_be), 32'h0000_000C);
    chk("t3_req_cycles", 32'(last_nreq), 32'd4);
    chk("t3_data", last_rdata, 32'hCAFE_F00D);

    // misaligned word load
    run_req(2'b10, 1'b0, 32'h0000_1001, 32'h0, 0, 0, 32'h1111_2222);
`ifdef DATAIO_MISALIGN_FAULT_EN
    chk("t4_cycle", 32'(last_vc), 32'd1);
    chk("t4_fault", 32'(last_fault), 32'd1);
    chk("t4_data", last_rdata, 32'h0);
`else
    chk("t4_addr", obs_addr, 32'h0000_1000);
    chk("t4_be", 32'(obs_be), 32'h0000_000F);
    chk("t4_fault", 32'(last_fault), 32'd0);
`endif

    // more patterns: lane selection, halfword store, order none
    run_req(2'b00, 1'b0, 32'h0000_3001, 32'h0, 1, 2, 32'h0BAD_CAFE);
    chk("t5_be", 32'(obs_be), 32'h0000_0002);
    run_req(2'b01, 1'b1, 32'h0000_4000, 32'hFFFF_BEEF, 0, 0, 32'h0);
    chk("t6_wdata", obs_wdata, 32'hBEEF_BEEF);
    chk("t6_be", 32'(obs_be), 32'h0000_0003);
    run_req(2'b11, 1'b0, 32'h0000_5000, 32'h0, 0, 0, 32'h5555_5555);
    chk("t7_cycle", 32'(last_vc), 32'd1);
    run_req(2'b10, 1'b1, 32'h8000_0000, 32'h0102_0304, 2, 1, 32'h0);

    // flush while waiting for the reply
    @(posedge clk); #1;
    core_req = 1'b1; core_order = 2'b10; core_rw = 1'b0; core_addr = 32'h0000_6000;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      core_req  = 1'b0;
      srst      = (c == 2);
      mem_valid = (c == 4);
      mem_rdata = 32'h7777_7777;
      chk("flush_busy", 32'(core_busy), 32'(c <= 4));
      chk("flush_no_valid", 32'(core_valid), 32'd0);
    end
    srst = 1'b0; mem_valid = 1'b0;
    run_req(2'b10, 1'b0, 32'h0000_6004, 32'h0, 0, 0, 32'h6666_6666);

    // asynchronous reset in the middle of a stalled request
    @(posedge clk); #1;
    core_req = 1'b1; core_order = 2'b10; core_rw = 1'b1; core_addr = 32'h0000_7000;
    core_wdata = 32'hFEED_FACE; core_pdt = 32'h1357_9BDF; core_tid = 14'h1ABC;
    mem_busy = 1'b1;
    @(posedge clk); #1;
    core_req = 1'b0;
    chk("arst_pre_req", 32'(mem_req), 32'd1);
    #2; rst_n = 1'b0; #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_busy", 32'(core_busy), 32'd0);
    chk("arst_addr", mem_addr, 32'h0);
    chk("arst_wdata", mem_wdata, 32'h0);
    chk("arst_pdt", mem_pdt, 32'h0);
    chk("arst_tid", 32'(mem_tid), 32'd0);
    chk("arst_rw", 32'(mem_rw), 32'd0);
    chk("arst_core_data", core_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_busy = 1'b0;
    @(posedge clk); #1;
    chk("arst_idle", 32'(core_busy), 32'd0);

    // stray memory replies while idle are ignored
    mem_valid = 1'b1; mem_rdata = 32'hBADB_ADBA;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("stray_valid", 32'(core_valid), 32'd0);
      chk("stray_busy", 32'(core_busy), 32'd0);
    end
    mem_valid = 1'b0;
    run_req(2'b00, 1'b0, 32'h0000_9002, 32'h0, 0, 0, 32'h89AB_CDEF);
    chk("t8_be", 32'(obs_be), 32'h0000_0004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
